button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1250000, stable-sample count required to accept a level change (10 ms at 125 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth; legal range 2..4.
REQ-003 i_clk  input  1  single system clock; all state on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous assert, active-high.
REQ-005 i_btn_raw  input  3  asynchronous push-button levels, 1 = pressed; bit 0 sel, bit 1 ge, bit 2 lt.
REQ-006 o_sel  output  1  one-cycle pulse per accepted sel press.
REQ-007 o_ge  output  1  one-cycle pulse per accepted ge press.
REQ-008 o_lt  output  1  one-cycle pulse per accepted lt press.
REQ-009 o_held  output  3  debounced level per button, same bit order as i_btn_raw.

Function
REQ-010 Each bit of i_btn_raw shall pass through its own SYNC_STAGES-deep flop chain before any other logic uses it.
REQ-011 Each button shall run an independent FSM: IDLE, PRESS_DB, PRESSED, RELEASE_DB.
REQ-012 IDLE -> PRESS_DB when synced level = 1; counter cleared to 0.
REQ-013 PRESS_DB: level 1 -> counter increments; level 0 -> return to IDLE, counter cleared.
REQ-014 PRESS_DB -> PRESSED when counter reaches DEBOUNCE_CYCLES-1 with level still 1; this transition raises the button's press event.
REQ-015 PRESSED -> RELEASE_DB when synced level = 0; counter cleared.
REQ-016 RELEASE_DB: level 0 -> counter increments; level 1 -> return to PRESSED, no new event.
REQ-017 RELEASE_DB -> IDLE when counter reaches DEBOUNCE_CYCLES-1 with level still 0; no event on release.
REQ-018 Counter width = $clog2(DEBOUNCE_CYCLES+1); counter saturates, never wraps.
REQ-019 o_held bit = 1 in PRESSED and RELEASE_DB, 0 otherwise.
REQ-020 Bounce-free press latency: pulse high on the cycle following the (SYNC_STAGES + DEBOUNCE_CYCLES)-th rising edge at which i_btn_raw is sampled 1.
REQ-021 Press held indefinitely: exactly one pulse; no auto-repeat.
REQ-022 At most one of o_sel/o_ge/o_lt high in any cycle; priority sel > ge > lt.
REQ-023 A press event losing arbitration shall set that button's pending flag; a pending event is issued in the first later cycle with no higher-priority event or pending flag.
REQ-024 A new event on a button whose pending flag is already set shall be dropped (pending depth 1).
REQ-025 Outputs shall be registered; no combinational path from i_btn_raw to any output.

Reset
REQ-026 i_rst = 1 shall immediately force FSMs to IDLE, counters to 0, sync flops to 0, pending flags to 0, and o_sel, o_ge, o_lt, o_held to 0.
REQ-027 Reset asserted mid-debounce shall discard the partial count and any pending event; no pulse is issued for it.
REQ-028 A button held through reset deassertion shall be treated as a new press and pulse once after the REQ-020 latency.

Structure
REQ-029 Shared package button_pkg shall hold NUM_BUTTONS = 3, button index constants BTN_SEL = 0, BTN_GE = 1, BTN_LT = 2, and the FSM state enum typedef.
REQ-030 Sub-module button_debouncer (synchronizer, FSM, counter; outputs level and press event) shall be instantiated NUM_BUTTONS times; arbitration and pending logic shall live in button_conditioner.

Verification (DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2)
REQ-031 Clean press: ge raw 0->1 held 20 cycles -> single o_ge pulse on cycle 7 after first high sample; o_held[1] = 1 from the same cycle.
REQ-032 Bounce: sel raw 1,1,0,1,1,1,1,1,... -> no pulse until 6 consecutive high samples after the glitch; exactly one o_sel pulse.
REQ-033 Simultaneous: sel and lt raised on the same edge -> o_sel at cycle 7, o_lt at cycle 8, never both high together.
REQ-034 Release glitch: lt held pressed, raw drops 0 for 2 cycles then returns 1 -> o_held[2] stays 1, no second pulse.
REQ-035 Reset mid-debounce: ge high, i_rst pulsed at cycle 4 while ge stays high -> all outputs 0 during reset; one o_ge pulse 7 cycles after reset deasserts.
REQ-036 Held press: sel held 1000 cycles, then released -> exactly one o_sel pulse; o_held[0] returns to 0 six cycles after the first low sample.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioner.
//   NUM_BUTTONS  number of conditioned buttons
//   BTN_*        bit index of each button in the raw/held vectors
//   btn_state_t  per-button debounce FSM state
package button_pkg;

    localparam int NUM_BUTTONS = 3;

    localparam int BTN_SEL = 0;
    localparam int BTN_GE  = 1;
    localparam int BTN_LT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_RELEASE_DB = 2'd3
    } btn_state_t;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bus between the board-side driver and the conditioner.
//   i_btn_raw  raw asynchronous button levels (1 = pressed)
//   o_sel      one-cycle pulse per accepted sel press
//   o_ge       one-cycle pulse per accepted ge press
//   o_lt       one-cycle pulse per accepted lt press
//   o_held     debounced level per button, same bit order as i_btn_raw
// master drives the raw levels and observes the outputs; slave is the conditioner.
// There is no handshake: pulses are single-cycle and must be consumed the cycle they appear.
interface button_conditioner_if;
    import button_pkg::*;

    logic [NUM_BUTTONS-1:0] i_btn_raw;
    logic                   o_sel;
    logic                   o_ge;
    logic                   o_lt;
    logic [NUM_BUTTONS-1:0] o_held;

    modport master (output i_btn_raw, input  o_sel, o_ge, o_lt, o_held);
    modport slave  (input  i_btn_raw, output o_sel, o_ge, o_lt, o_held);

endinterface

// File: rtl/button_debouncer.sv
// Single-button synchronizer + debounce FSM.
//   i_clk      system clock
//   i_rst      asynchronous active-high reset
//   i_btn_raw  raw asynchronous button level
//   o_level    debounced level (1 in PRESSED and RELEASE_DB)
//   o_press    one-cycle press event on PRESS_DB -> PRESSED
//   o_state    current FSM state, exposed for debug
// SYNC_STAGES is expected to lie in 2..4.
module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1250000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_raw,
    output logic       o_level,
    output logic       o_press,
    output btn_state_t o_state
);

    localparam int unsigned CW      = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter reaches DEBOUNCE_CYCLES-1 on the edge where it currently
    // holds DEBOUNCE_CYCLES-2; the transition is taken on that edge.
    localparam int unsigned DONE_AT = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    btn_state_t             state_q;
    logic                   level;
    logic                   cnt_done;
    logic [CW-1:0]          cnt_inc;

    assign level    = sync_q[SYNC_STAGES-1];
    assign cnt_done = (cnt_q >= CW'(DONE_AT));
    // Saturating increment: the counter never wraps.
    assign cnt_inc  = (cnt_q == CW'(DEBOUNCE_CYCLES)) ? cnt_q : cnt_q + CW'(1);
    assign o_state  = state_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            o_press <= 1'b0;
            o_level <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_btn_raw};
            o_press <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (level) begin
                        state_q <= ST_PRESS_DB;
                        cnt_q   <= '0;
                    end
                end
                ST_PRESS_DB: begin
                    if (!level) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_done) begin
                        state_q <= ST_PRESSED;
                        o_press <= 1'b1;
                        o_level <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_PRESSED: begin
                    if (!level) begin
                        state_q <= ST_RELEASE_DB;
                        cnt_q   <= '0;
                    end
                end
                ST_RELEASE_DB: begin
                    if (level) begin
                        state_q <= ST_PRESSED;
                    end else if (cnt_done) begin
                        state_q <= ST_IDLE;
                        o_level <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    o_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Three-button conditioner: per-button debounce plus one-hot press-pulse arbitration.
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   bus          button_conditioner_if slave (raw levels in, pulses/held levels out)
//   o_dbg_state  packed per-button FSM states, 2 bits each, button 0 in the LSBs
// Pulse priority is sel > ge > lt. A press that loses arbitration waits in a
// one-deep pending flag; a further press on a button already pending is dropped.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1250000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    button_conditioner_if.slave      bus,
    output logic [2*NUM_BUTTONS-1:0] o_dbg_state
);

    logic [NUM_BUTTONS-1:0] level;
    logic [NUM_BUTTONS-1:0] press;
    logic [NUM_BUTTONS-1:0] pend_q;
    logic [NUM_BUTTONS-1:0] req;
    logic [NUM_BUTTONS-1:0] grant;
    btn_state_t             state [NUM_BUTTONS];

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_debouncer (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_btn_raw (bus.i_btn_raw[i]),
            .o_level   (level[i]),
            .o_press   (press[i]),
            .o_state   (state[i])
        );
        assign o_dbg_state[2*i +: 2] = state[i];
    end

    // A pending flag competes exactly like a fresh event of the same button.
    always_comb begin
        req   = pend_q | press;
        grant = '0;
        if (req[BTN_SEL]) begin
            grant[BTN_SEL] = 1'b1;
        end else if (req[BTN_GE]) begin
            grant[BTN_GE] = 1'b1;
        end else if (req[BTN_LT]) begin
            grant[BTN_LT] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend_q     <= '0;
            bus.o_sel  <= 1'b0;
            bus.o_ge   <= 1'b0;
            bus.o_lt   <= 1'b0;
            bus.o_held <= '0;
        end else begin
            pend_q     <= req & ~grant;
            bus.o_sel  <= grant[BTN_SEL];
            bus.o_ge   <= grant[BTN_GE];
            bus.o_lt   <= grant[BTN_LT];
            bus.o_held <= level;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
    import button_pkg::*;

    localparam int W = 19; // {edge number[15:0], pulse code {lt,ge,sel}}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    logic [2*NUM_BUTTONS-1:0] dbg_state;
    button_conditioner_if bif ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bif),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [W-1:0] mk(input int e, input logic [2:0] code);
        logic [31:0] ev;
        ev = e;
        return {ev[15:0], code};
    endfunction

    // Every observed pulse is matched against the next expected one (edge + code).
    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] want;
        logic [31:0]  ec;
        if (bif.o_sel || bif.o_ge || bif.o_lt) begin
            ec  = edge_cnt;
            got = {ec[15:0], bif.o_lt, bif.o_ge, bif.o_sel};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: got edge %0d code %b, required no pulse", ec[15:0], got[2:0]);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL pulse_match: got edge %0d code %b, required edge %0d code %b",
                             got[W-1:3], got[2:0], want[W-1:3], want[2:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected pulses missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.i_btn_raw = 3'b111;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bif.o_sel, bif.o_ge, bif.o_lt, bif.o_held, dbg_state} !== 12'd0) begin
                errors++;
                $display("FAIL reset_outputs: got %b, required all zero",
                         {bif.o_sel, bif.o_ge, bif.o_lt, bif.o_held, dbg_state});
            end
        end
        bif.i_btn_raw = 3'b000;
        rst = 1'b0;
        idle(10);
        checks++;
        if ({bif.o_sel, bif.o_ge, bif.o_lt, bif.o_held} !== 6'd0) begin
            errors++;
            $display("FAIL idle_outputs: got %b, required all zero",
                     {bif.o_sel, bif.o_ge, bif.o_lt, bif.o_held});
        end
    endtask

    task automatic test_clean_press();
        int n;
        @(negedge clk);
        n = edge_cnt;
        bif.i_btn_raw = 3'b010;
        exp_q.push_back(mk(n + 7, 3'b010));
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            checks++;
            if (bif.o_held !== ((edge_cnt >= n + 7) ? 3'b010 : 3'b000)) begin
                errors++;
                $display("FAIL clean_held: edge +%0d got %b, required %b", edge_cnt - n, bif.o_held,
                         (edge_cnt >= n + 7) ? 3'b010 : 3'b000);
            end
        end
        bif.i_btn_raw = 3'b000;
        idle(12);
        checks++;
        if (bif.o_held !== 3'b000) begin
            errors++;
            $display("FAIL clean_release: got held %b, required 000", bif.o_held);
        end
        check_drained("clean");
    endtask

    task automatic test_bounce();
        int n;
        @(negedge clk);
        n = edge_cnt;
        bif.i_btn_raw = 3'b001;
        // Glitch sampled on the third edge; six clean samples after it give the pulse.
        exp_q.push_back(mk(n + 10, 3'b001));
        @(negedge clk);
        @(negedge clk);
        bif.i_btn_raw = 3'b000;
        @(negedge clk);
        bif.i_btn_raw = 3'b001;
        idle(15);
        bif.i_btn_raw = 3'b000;
        idle(12);
        check_drained("bounce");
    endtask

    task automatic test_simultaneous();
        int n;
        @(negedge clk);
        n = edge_cnt;
        bif.i_btn_raw = 3'b101;
        exp_q.push_back(mk(n + 7, 3'b001));
        exp_q.push_back(mk(n + 8, 3'b100));
        idle(15);
        bif.i_btn_raw = 3'b000;
        idle(12);
        check_drained("simul");
    endtask

    task automatic test_all_three();
        int n;
        @(negedge clk);
        n = edge_cnt;
        bif.i_btn_raw = 3'b111;
        exp_q.push_back(mk(n + 7, 3'b001));
        exp_q.push_back(mk(n + 8, 3'b010));
        exp_q.push_back(mk(n + 9, 3'b100));
        idle(15);
        bif.i_btn_raw = 3'b000;
        idle(12);
        check_drained("all3");
    endtask

    task automatic test_release_glitch();
        int n;
        @(negedge clk);
        n = edge_cnt;
        bif.i_btn_raw = 3'b100;
        exp_q.push_back(mk(n + 7, 3'b100));
        idle(15);
        bif.i_btn_raw = 3'b000;
        for (int j = 0; j < 16; j++) begin
            if (j == 2) bif.i_btn_raw = 3'b100;
            @(negedge clk);
            checks++;
            if (bif.o_held !== 3'b100) begin
                errors++;
                $display("FAIL glitch_held: step %0d got %b, required 100", j, bif.o_held);
            end
        end
        bif.i_btn_raw = 3'b000;
        idle(12);
        check_drained("glitch");
    endtask

    task automatic test_reset_mid();
        int n;
        int m;
        @(negedge clk);
        n = edge_cnt;
        bif.i_btn_raw = 3'b010;
        idle(3);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({bif.o_sel, bif.o_ge, bif.o_lt, bif.o_held} !== 6'd0) begin
                errors++;
                $display("FAIL midreset_outputs: got %b, required all zero",
                         {bif.o_sel, bif.o_ge, bif.o_lt, bif.o_held});
            end
        end
        m = edge_cnt;
        rst = 1'b0;
        exp_q.push_back(mk(m + 7, 3'b010));
        idle(15);
        checks++;
        if (bif.o_held !== 3'b010) begin
            errors++;
            $display("FAIL midreset_held: got %b, required 010 (start edge %0d)", bif.o_held, n);
        end
        bif.i_btn_raw = 3'b000;
        idle(12);
        check_drained("midreset");
    endtask

    task automatic test_async_reset();
        int n;
        @(negedge clk);
        n = edge_cnt;
        bif.i_btn_raw = 3'b001;
        exp_q.push_back(mk(n + 7, 3'b001));
        idle(10);
        checks++;
        if (bif.o_held !== 3'b001) begin
            errors++;
            $display("FAIL async_pre_held: got %b, required 001", bif.o_held);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bif.o_held, dbg_state} !== 9'd0) begin
            errors++;
            $display("FAIL async_reset: got held/state %b, required zero before any clock edge",
                     {bif.o_held, dbg_state});
        end
        bif.i_btn_raw = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        idle(12);
        check_drained("async");
    endtask

    task automatic test_held_long();
        int n;
        int r;
        @(negedge clk);
        n = edge_cnt;
        bif.i_btn_raw = 3'b001;
        exp_q.push_back(mk(n + 7, 3'b001));
        idle(1000);
        r = edge_cnt;
        bif.i_btn_raw = 3'b000;
        idle(6);
        checks++;
        if (bif.o_held !== 3'b001) begin
            errors++;
            $display("FAIL held_before_drop: edge +%0d got %b, required 001", edge_cnt - r, bif.o_held);
        end
        @(negedge clk);
        checks++;
        if (bif.o_held !== 3'b000) begin
            errors++;
            $display("FAIL held_drop: edge +%0d got %b, required 000", edge_cnt - r, bif.o_held);
        end
        idle(8);
        check_drained("held");
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 8; it++) begin
            int          off [3];
            int          ev  [3];
            int          lo;
            logic [2:0]  mask;
            logic [2:0]  pend;
            logic [2:0]  req;
            logic [2:0]  grant;
            mask = 3'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++) begin
                off[i] = $urandom_range(0, 3);
                ev[i]  = 0;
            end
            lo = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (k == 0) lo = edge_cnt;
                for (int i = 0; i < 3; i++) begin
                    if (mask[i] && off[i] == k) begin
                        bif.i_btn_raw[i] = 1'b1;
                        ev[i] = edge_cnt + 6;
                    end
                end
            end
            // Reference arbitration: priority sel > ge > lt, one-deep pending per button.
            pend = 3'b000;
            for (int t = lo + 6; t <= lo + 14; t++) begin
                for (int i = 0; i < 3; i++) req[i] = pend[i] | (mask[i] && ev[i] == t);
                grant = 3'b000;
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                if (grant != 3'b000) exp_q.push_back(mk(t + 1, grant));
                pend = req & ~grant;
            end
            idle(15);
            bif.i_btn_raw = 3'b000;
            idle(10);
            check_drained("b2b");
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        bif.i_btn_raw = 3'b000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_all_three();
        test_release_glitch();
        test_reset_mid();
        test_async_reset();
        test_held_long();
        test_back_to_back();
        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
